// File: rtl/perf_cnt_pkg.sv
// Shared types and arithmetic for the perf_counter_bank event counters.
package perf_cnt_pkg;

   typedef enum logic [1:0] {
      COUNT  = 2'd0,
      FROZEN = 2'd1,
      CLEAR  = 2'd2
   } pc_state_t;

   localparam int MAX_CH = 16;

   // Returns {overflow, next_value}; the value is zero-extended to 32 bits.
   function automatic logic [32:0] next_count(input logic [31:0] cur,
                                              input logic [31:0] max_val,
                                              input logic        sat);
      if (cur == max_val)
         return {1'b1, (sat ? max_val : 32'd0)};
      return {1'b0, cur + 32'd1};
   endfunction

endpackage

// File: rtl/perf_cnt_chan.sv
// One event counter with its sticky overflow flag; clr wins over inc.
module perf_cnt_chan
   import perf_cnt_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt,
   output logic             ovf
);

   localparam logic [31:0] MAX_VAL = 32'((64'd1 << WIDTH) - 64'd1);

   logic [32:0] nx;

   assign nx = next_count(32'(cnt), MAX_VAL, (SATURATE != 0));

   generate
      if (WIDTH < 32) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^nx[31:WIDTH];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (inc) begin
         cnt <= nx[WIDTH-1:0];
         if (nx[32]) ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// N_CH-channel event counter bank with freeze, swept clear and registered read.
// Optional shadow snapshot bank when PERF_CNT_SNAPSHOT_EN is defined.
module perf_counter_bank
   import perf_cnt_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int WIDTH    = 32,
   parameter int SATURATE = 0,
   parameter int SEL_W    = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  ev,
   input  logic             en,
   input  logic             freeze,
   input  logic             clr_req,
`ifdef PERF_CNT_SNAPSHOT_EN
   input  logic             snap,
   input  logic             rd_snap,
`endif
   output logic             busy,
   output logic             clr_done,
   input  logic [SEL_W-1:0] rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic [N_CH-1:0]  ovf
);

   localparam logic [SEL_W:0]   N_CH_X   = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CH - 1);

   pc_state_t               state, nxt_state;
   logic [SEL_W-1:0]        sweep_idx, nxt_idx;
   logic                    count_en;
   logic [N_CH-1:0]         clr_vec;
   logic [N_CH-1:0][WIDTH-1:0] cnt_all;
   logic [WIDTH-1:0]        rd_src;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= COUNT;
         sweep_idx <= '0;
      end else begin
         state     <= nxt_state;
         sweep_idx <= nxt_idx;
      end
   end

   // clr_req outranks freeze; a request arriving mid-sweep is dropped.
   always_comb begin
      nxt_state = state;
      nxt_idx   = '0;
      case (state)
         COUNT: begin
            if (clr_req)     nxt_state = CLEAR;
            else if (freeze) nxt_state = FROZEN;
         end
         FROZEN: begin
            if (clr_req)      nxt_state = CLEAR;
            else if (!freeze) nxt_state = COUNT;
         end
         CLEAR: begin
            if (sweep_idx == LAST_IDX) nxt_state = freeze ? FROZEN : COUNT;
            else                       nxt_idx   = sweep_idx + 1'b1;
         end
         default: nxt_state = COUNT;
      endcase
   end

   always_comb begin
      busy     = (state == CLEAR);
      clr_done = busy && (sweep_idx == LAST_IDX);
      count_en = (state == COUNT) && en;
      clr_vec  = '0;
      for (int i = 0; i < N_CH; i++)
         clr_vec[i] = busy && (sweep_idx == SEL_W'(i));
   end

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         perf_cnt_chan #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_chan (
            .clk (clk),
            .rst (rst),
            .inc (count_en & ev[i]),
            .clr (clr_vec[i]),
            .cnt (cnt_all[i]),
            .ovf (ovf[i])
         );
      end
   endgenerate

`ifdef PERF_CNT_SNAPSHOT_EN
   logic [N_CH-1:0][WIDTH-1:0] shadow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          shadow <= '0;
      else if (snap && state != CLEAR)   shadow <= cnt_all;
   end

   always_comb begin
      rd_src = '0;
      if ({1'b0, rd_sel} < N_CH_X)
         rd_src = rd_snap ? shadow[rd_sel] : cnt_all[rd_sel];
   end
`else
   always_comb begin
      rd_src = '0;
      if ({1'b0, rd_sel} < N_CH_X)
         rd_src = cnt_all[rd_sel];
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_data <= '0;
      else      rd_data <= rd_src;
   end

endmodule
